usb2_utmi_link_tx: RTL and testbench



---
 rtl/usb2_utmi_link_tx.sv | 206 ++++++++++++++++++++
 tb/tb_usb2_utmi_link_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb2_utmi_link_tx.sv
// UTMI link-side packet transmitter: PID byte, optional payload, CRC16, then an inter-packet gap.
// Optional feature macro: USB2_LINK_TX_PID_CHECK_EN (reject PIDs a device never transmits).
module usb2_utmi_link_tx #(
   parameter int MAX_PKT_BYTES = 512,
   parameter int IPG_CYCLES    = 8,
   localparam int LW = $clog2(MAX_PKT_BYTES + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_pkt_valid,
   input  logic [3:0]    i_pkt_pid,
   input  logic [LW-1:0] i_pkt_len,
   output logic          o_pkt_ready,
   input  logic [7:0]    i_pl_data,
   input  logic          i_pl_valid,
   output logic          o_pl_ready,
   output logic [7:0]    o_utmi_txdata,
   output logic          o_utmi_txvalid,
   input  logic          i_utmi_txready,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_underrun,
   output logic          o_pid_err
);

   localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PID,
      S_DATA,
      S_CRC_LO,
      S_CRC_HI,
      S_GAP
   } state_t;

   state_t        r_state, w_state;
   logic          r_is_data, w_is_data;
   logic [LW-1:0] r_cnt, w_cnt;
   logic [GW-1:0] r_gap, w_gap;
   logic [15:0]   r_crc, w_crc;
   logic [7:0]    r_txdata, w_txdata;
   logic          r_txvalid, w_txvalid;
   logic          r_ready, w_ready;
   logic          r_busy, w_busy;
   logic          r_done, w_done;
   logic          r_underrun, w_underrun;

   logic          w_accept;
   logic          w_pid_ok;
   logic          w_reject;
   logic          w_consume;
   logic          w_owed;
   logic [LW-1:0] w_len_clamped;

   // USB CRC16 in reflected form (0xA001), one byte LSB-first.
   function automatic logic [15:0] crc16Byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
         else                c = c >> 1;
      end
      return c;
   endfunction

`ifdef USB2_LINK_TX_PID_CHECK_EN
   // Data PIDs end in 2'b11 and handshake PIDs in 2'b10; tokens and specials are refused.
   assign w_pid_ok = i_pkt_pid[1];
`else
   assign w_pid_ok = 1'b1;
`endif

   assign w_accept      = r_ready & i_pkt_valid;
   assign w_reject      = w_accept & ~w_pid_ok;
   assign w_consume     = r_txvalid & i_utmi_txready;
   assign w_owed        = ((r_state == S_PID) || (r_state == S_DATA)) && (r_cnt != '0);
   assign w_len_clamped = (i_pkt_len > LW'(MAX_PKT_BYTES)) ? LW'(MAX_PKT_BYTES) : i_pkt_len;

   assign o_pl_ready     = i_utmi_txready & r_txvalid & w_owed;
   assign o_pkt_ready    = r_ready;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_underrun     = r_underrun;
   assign o_utmi_txdata  = r_txdata;
   assign o_utmi_txvalid = r_txvalid;

   // The state names what is currently sitting in the TxData register.
   always_comb begin
      w_state    = r_state;
      w_is_data  = r_is_data;
      w_cnt      = r_cnt;
      w_gap      = r_gap;
      w_crc      = r_crc;
      w_txdata   = r_txdata;
      w_txvalid  = r_txvalid;
      w_done     = 1'b0;
      w_underrun = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_pid_ok) begin
               w_is_data = (i_pkt_pid[1:0] == 2'b11);
               w_cnt     = (i_pkt_pid[1:0] == 2'b11) ? w_len_clamped : '0;
               w_crc     = 16'hFFFF;
               w_txdata  = {~i_pkt_pid, i_pkt_pid};
               w_txvalid = 1'b1;
               w_state   = S_PID;
            end
         end
         S_PID, S_DATA: begin
            if (w_consume) begin
               if (w_owed) begin
                  if (i_pl_valid) begin
                     w_txdata = i_pl_data;
                     w_crc    = crc16Byte(r_crc, i_pl_data);
                     w_cnt    = r_cnt - LW'(1);
                     w_state  = S_DATA;
                  end else begin
                     w_txvalid  = 1'b0;
                     w_txdata   = 8'h00;
                     w_underrun = 1'b1;
                     w_gap      = GW'(IPG_CYCLES - 1);
                     w_state    = S_GAP;
                  end
               end else if (r_is_data) begin
                  w_txdata = ~r_crc[7:0];
                  w_state  = S_CRC_LO;
               end else begin
                  w_txvalid = 1'b0;
                  w_txdata  = 8'h00;
                  w_done    = 1'b1;
                  w_gap     = GW'(IPG_CYCLES - 1);
                  w_state   = S_GAP;
               end
            end
         end
         S_CRC_LO: begin
            if (w_consume) begin
               w_txdata = ~r_crc[15:8];
               w_state  = S_CRC_HI;
            end
         end
         S_CRC_HI: begin
            if (w_consume) begin
               w_txvalid = 1'b0;
               w_txdata  = 8'h00;
               w_done    = 1'b1;
               w_gap     = GW'(IPG_CYCLES - 1);
               w_state   = S_GAP;
            end
         end
         S_GAP: begin
            if (r_gap == '0) w_state = S_IDLE;
            else             w_gap   = r_gap - GW'(1);
         end
         default: begin
            w_state   = S_IDLE;
            w_txvalid = 1'b0;
         end
      endcase
      w_ready = (w_state == S_IDLE) && !w_reject;
      w_busy  = (w_state != S_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_is_data  <= 1'b0;
         r_cnt      <= '0;
         r_gap      <= '0;
         r_crc      <= 16'hFFFF;
         r_txdata   <= 8'h00;
         r_txvalid  <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_is_data  <= w_is_data;
         r_cnt      <= w_cnt;
         r_gap      <= w_gap;
         r_crc      <= w_crc;
         r_txdata   <= w_txdata;
         r_txvalid  <= w_txvalid;
         r_ready    <= w_ready;
         r_busy     <= w_busy;
         r_done     <= w_done;
         r_underrun <= w_underrun;
      end
   end

`ifdef USB2_LINK_TX_PID_CHECK_EN
   logic r_pid_err;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_pid_err <= 1'b0;
      else       r_pid_err <= w_reject;
   end

   assign o_pid_err = r_pid_err;
`else
   assign o_pid_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb2_utmi_link_tx.sv
// Randomised bench for usb2_utmi_link_tx against a byte-position packet model, plus directed literal checks.
`timescale 1ns/1ps
module tb_usb2_utmi_link_tx;

   localparam int MAXB = 512;
   localparam int IPG  = 8;
   localparam int LW   = $clog2(MAXB + 1);

   typedef logic [7:0] byteQ_t[$];
   typedef enum int {P_IDLE, P_SEND, P_GAP, P_REJ} phase_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_pkt_valid = 1'b0;
   logic [3:0]    i_pkt_pid = 4'h0;
   logic [LW-1:0] i_pkt_len = '0;
   logic          o_pkt_ready;
   logic [7:0]    i_pl_data = 8'h00;
   logic          i_pl_valid = 1'b0;
   logic          o_pl_ready;
   logic [7:0]    o_utmi_txdata;
   logic          o_utmi_txvalid;
   logic          i_utmi_txready = 1'b0;
   logic          o_busy, o_done, o_underrun, o_pid_err;

   always #5 clk = ~clk;

   usb2_utmi_link_tx #(.MAX_PKT_BYTES(MAXB), .IPG_CYCLES(IPG)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_pkt_valid(i_pkt_valid), .i_pkt_pid(i_pkt_pid), .i_pkt_len(i_pkt_len), .o_pkt_ready(o_pkt_ready),
      .i_pl_data(i_pl_data), .i_pl_valid(i_pl_valid), .o_pl_ready(o_pl_ready),
      .o_utmi_txdata(o_utmi_txdata), .o_utmi_txvalid(o_utmi_txvalid), .i_utmi_txready(i_utmi_txready),
      .o_busy(o_busy), .o_done(o_done), .o_underrun(o_underrun), .o_pid_err(o_pid_err)
   );

   int totalCnt = 0;
   int badCnt   = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act !== exp) begin
         badCnt++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Wire CRC16 computed with a left-shifting 0x8005 register, then bit-reversed and inverted.
   function automatic logic [15:0] usbCrcWire(input byteQ_t b);
      logic [15:0] r;
      logic [15:0] w;
      logic        fb;
      r = 16'hFFFF;
      foreach (b[i]) begin
         for (int k = 0; k < 8; k++) begin
            fb = r[15] ^ b[i][k];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
         end
      end
      for (int k = 0; k < 16; k++) w[k] = ~r[15-k];
      return w;
   endfunction

   // Payload source and per-packet observations.
   logic [7:0] srcPay [1024];
   int         srcLen = 0, srcIdx = 0, srcUnder = -1;
   bit         plTaken = 0;
   byteQ_t     busLog;
   int         doneCnt = 0, underCnt = 0, errCnt = 0;
   int         cyc = 0, acceptCyc = -1, turnaround = -1;
   bit         accepted = 0, pktEnded = 0;

   // Model state: which byte of the packet is on the bus and what must follow.
   phase_t      mPhase = P_IDLE;
   bit          mRst = 1;
   int          mPos = 0, mNPay = 0, mTot = 0, mGap = 0;
   logic [7:0]  mCur = 8'h00;
   logic [15:0] mCrc = 16'h0000;
   byteQ_t      mPay;
   bit          mExpDone = 0, mExpUnder = 0, mExpErr = 0;

   // Per-cycle comparison of every output against the model, then the model steps one clock.
   always @(negedge clk) begin : cmp
      bit         nDone, nUnder, nErr, isData, ok;
      logic [3:0] pid;
      int         lenC;
      cyc++;
      plTaken = o_pl_ready && i_pl_valid;
      if (mRst) begin
         checkOutput("reset_outputs",
            {17'd0, o_utmi_txdata, o_utmi_txvalid, o_pkt_ready, o_pl_ready, o_busy, o_done, o_underrun, o_pid_err}, 32'd0);
      end else begin
         checkOutput("pkt_ready", o_pkt_ready, (mPhase == P_IDLE));
         checkOutput("busy", o_busy, (mPhase == P_SEND) || (mPhase == P_GAP));
         checkOutput("txvalid", o_utmi_txvalid, (mPhase == P_SEND));
         checkOutput("pl_ready", o_pl_ready, (mPhase == P_SEND) && i_utmi_txready && (mPos < mNPay));
         checkOutput("done", o_done, mExpDone);
         checkOutput("underrun", o_underrun, mExpUnder);
         checkOutput("pid_err", o_pid_err, mExpErr);
         if (mPhase == P_SEND) checkOutput("txdata", o_utmi_txdata, mCur);
      end
      if (o_done === 1'b1)     doneCnt++;
      if (o_underrun === 1'b1) underCnt++;
      if (o_pid_err === 1'b1)  errCnt++;
      if (o_pkt_ready === 1'b1 && turnaround < 0 && acceptCyc >= 0 && cyc > acceptCyc)
         turnaround = cyc - acceptCyc;

      nDone = 0; nUnder = 0; nErr = 0;
      if (rst) begin
         if (mPhase != P_IDLE) pktEnded = 1;
         mPhase = P_IDLE;
      end else if (mRst) begin
         mPhase = P_IDLE;
      end else begin
         case (mPhase)
            P_IDLE: if (i_pkt_valid) begin
               accepted   = 1;
               acceptCyc  = cyc;
               turnaround = -1;
               pid        = i_pkt_pid;
               isData     = (pid[1:0] == 2'b11);
               ok         = 1;
`ifdef USB2_LINK_TX_PID_CHECK_EN
               ok = isData || (pid == 4'b0010) || (pid == 4'b1010) || (pid == 4'b1110) || (pid == 4'b0110);
`endif
               if (!ok) begin
                  nErr = 1; mPhase = P_REJ; pktEnded = 1;
               end else begin
                  lenC   = (int'(i_pkt_len) > MAXB) ? MAXB : int'(i_pkt_len);
                  mNPay  = isData ? lenC : 0;
                  mTot   = isData ? mNPay + 3 : 1;
                  mPos   = 0;
                  mCur   = {~pid, pid};
                  mPay.delete();
                  mPhase = P_SEND;
               end
            end
            P_SEND: if (i_utmi_txready) begin
               busLog.push_back(mCur);
               if (mPos == mTot - 1) begin
                  nDone = 1; mPhase = P_GAP; mGap = IPG; pktEnded = 1;
               end else if (mPos < mNPay) begin
                  if (i_pl_valid) begin
                     mCur = i_pl_data; mPay.push_back(i_pl_data); mPos++;
                  end else begin
                     nUnder = 1; mPhase = P_GAP; mGap = IPG; pktEnded = 1;
                  end
               end else if (mPos == mNPay) begin
                  mCrc = usbCrcWire(mPay); mCur = mCrc[7:0]; mPos++;
               end else begin
                  mCur = mCrc[15:8]; mPos++;
               end
            end
            P_GAP: begin
               mGap--;
               if (mGap == 0) mPhase = P_IDLE;
            end
            default: mPhase = P_IDLE;
         endcase
      end
      mRst      = rst;
      mExpDone  = nDone;
      mExpUnder = nUnder;
      mExpErr   = nErr;
   end

   // One clock of input driving, just after the rising edge.
   task automatic tick(input int txMode);
      @(posedge clk);
      #1;
      if (plTaken) srcIdx++;
      i_utmi_txready = (txMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      i_pl_valid     = (srcIdx < srcLen) && (srcIdx != srcUnder) && (srcIdx < 1024);
      i_pl_data      = (srcIdx < 1024) ? srcPay[srcIdx] : 8'h00;
   endtask

   task automatic applyStimulus(input logic [3:0] pid, input int len, input int txMode,
                                input int underAt, input int rstAt, input bit counting, input bit waitIdle);
      int k;
      busLog.delete();
      doneCnt = 0; underCnt = 0; errCnt = 0;
      turnaround = -1; accepted = 0; pktEnded = 0;
      for (int i = 0; i < 1024; i++) srcPay[i] = counting ? 8'(i) : 8'($urandom);
      srcLen = len; srcIdx = 0; srcUnder = underAt;
      i_pkt_pid = pid; i_pkt_len = LW'(len); i_pkt_valid = 1'b1;
      k = 0;
      while (!accepted && k < 60) begin
         tick(txMode);
         k++;
      end
      i_pkt_valid = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
      k = 0;
      while (!(waitIdle ? (turnaround >= 0) : pktEnded) && k < 4000) begin
         if (k == rstAt) begin
            rst = 1'b1;
            repeat (3) tick(txMode);
            rst = 1'b0;
            k += 3;
         end
         tick(txMode);
         k++;
      end
      if (k >= 4000) checkOutput("packet_timeout", 32'd0, 32'd1);
   endtask

   task automatic checkBus(input string name, input byteQ_t exp);
      checkOutput({name, "_count"}, busLog.size(), exp.size());
      for (int i = 0; i < exp.size() && i < busLog.size(); i++)
         checkOutput({name, "_byte"}, busLog[i], exp[i]);
   endtask

   initial begin
      byteQ_t exp;
      byteQ_t pay;
      logic [15:0] crc;
      int len, under;

      exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      checkOutput("crc_model_pin", usbCrcWire(exp), 16'hB4C8);

      repeat (3) tick(0);
      rst = 1'b0;
      tick(0);
      @(negedge clk);
      checkOutput("ready_after_reset", o_pkt_ready, 1);

      $display("[TB] ACK handshake");
      applyStimulus(4'b0010, 0, 0, -1, -1, 1, 1);
      exp = '{8'hD2};
      checkBus("ack_bus", exp);
      checkOutput("ack_done", doneCnt, 1);
      checkOutput("ack_turnaround", turnaround, 1 + 1 + IPG);

      $display("[TB] DATA0 zero length");
      applyStimulus(4'b0011, 0, 0, -1, -1, 1, 1);
      exp = '{8'hC3, 8'h00, 8'h00};
      checkBus("zlp_bus", exp);
      checkOutput("zlp_done", doneCnt, 1);
      checkOutput("zlp_turnaround", turnaround, 3 + 1 + IPG);

      $display("[TB] DATA1 four bytes with stalls");
      applyStimulus(4'b1011, 4, 1, -1, -1, 1, 1);
      pay = '{8'h00, 8'h01, 8'h02, 8'h03};
      crc = usbCrcWire(pay);
      exp = '{8'h4B, 8'h00, 8'h01, 8'h02, 8'h03};
      exp.push_back(crc[7:0]);
      exp.push_back(crc[15:8]);
      checkBus("data1_bus", exp);
      checkOutput("data1_done", doneCnt, 1);

      $display("[TB] DATA0 underrun at byte 10");
      applyStimulus(4'b0011, 64, 0, 10, -1, 1, 1);
      checkOutput("under_bytes", busLog.size(), 11);
      if (busLog.size() == 11) checkOutput("under_last", busLog[10], 8'h09);
      checkOutput("under_pulse", underCnt, 1);
      checkOutput("under_no_done", doneCnt, 0);

      $display("[TB] reset mid-packet");
      applyStimulus(4'b0011, 20, 0, -1, 6, 1, 1);
      checkOutput("rst_no_done", doneCnt, 0);
      checkOutput("rst_no_under", underCnt, 0);

      $display("[TB] oversize length clamp");
      applyStimulus(4'b0111, 600, 0, -1, -1, 0, 1);
      checkOutput("clamp_bytes", busLog.size(), MAXB + 3);
      checkOutput("clamp_done", doneCnt, 1);

      $display("[TB] OUT token request");
      applyStimulus(4'b0001, 5, 0, -1, -1, 1, 1);
`ifdef USB2_LINK_TX_PID_CHECK_EN
      checkOutput("out_pid_err", errCnt, 1);
      checkOutput("out_no_bytes", busLog.size(), 0);
      checkOutput("out_turnaround", turnaround, 2);
`else
      exp = '{8'hE1};
      checkBus("out_bus", exp);
      checkOutput("out_no_err", errCnt, 0);
      checkOutput("out_done", doneCnt, 1);
`endif

      $display("[TB] randomised packets");
      for (int n = 0; n < 40; n++) begin
         len   = $urandom_range(0, 40);
         under = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
         applyStimulus(4'($urandom_range(0, 15)), len, $urandom_range(0, 1), under, -1, 0, 0);
      end
      repeat (IPG + 4) tick(1);

      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
